// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit bus-based CPU datapath.
// Steps the fetch/execute T-states, decodes IR and drives one strobe set per clock (Moore).
//
// Ports:
//   Clock     - rising-edge clock
//   Clear     - synchronous active-low reset
//   IR        - instruction register contents (op/ra/rb/rc fields read in T3..T6 only)
//   MemReady  - memory read data valid, only looked at in T1
//   PCout, ZHighout, Zlowout, MDRout         - bus drive strobes
//   MARin, PCin, MDRin, IRin, Yin, IncPC, Read - load/control strobes
//   ZLowIn, ZHighIn, HIin, LOin               - result register loads
//   ALUop     - ALU operation code (the opcode itself, during T4)
//   Rin, Rout - one-hot general register load/drive selects
//   Run       - high in T0..T6, low in reset and halt
//   IllegalOp - one-cycle pulse in T3 for an undecodable opcode
//
// Build option: define CONTROL_SEQUENCER_MULDIV_EN to decode mul/div (T6 becomes reachable).
// Without it mul/div take the illegal path and ZHighIn/HIin/LOin/ZHighout stay 0.

module control_sequencer #(
  parameter int unsigned IR_W = 32,
  parameter int unsigned NREG = 16
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic [IR_W-1:0] IR,
  input  logic            MemReady,
  output logic            PCout,
  output logic            ZHighout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            HIin,
  output logic            LOin,
  output logic [4:0]      ALUop,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Run,
  output logic            IllegalOp
);

  localparam logic [3:0] StReset = 4'd0;
  localparam logic [3:0] StT0    = 4'd1;
  localparam logic [3:0] StT1    = 4'd2;
  localparam logic [3:0] StT2    = 4'd3;
  localparam logic [3:0] StT3    = 4'd4;
  localparam logic [3:0] StT4    = 4'd5;
  localparam logic [3:0] StT5    = 4'd6;
  localparam logic [3:0] StT6    = 4'd7;
  localparam logic [3:0] StHalt  = 4'd8;

  localparam logic [4:0] OpAluLo = 5'b00011;
  localparam logic [4:0] OpAluHi = 5'b01011;
  localparam logic [4:0] OpMul   = 5'b01111;
  localparam logic [4:0] OpDiv   = 5'b10000;
  localparam logic [4:0] OpNop   = 5'b11010;
  localparam logic [4:0] OpHalt  = 5'b11011;

  logic [3:0] state_q, state_d;
  // Set once T1 has waited a cycle; keeps PCin to the first T1 cycle only.
  logic       t1_wait_q, t1_wait_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_nop, is_halt;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];

  logic unused_ir;
  assign unused_ir = ^IR[14:0];

  assign is_alu  = (op >= OpAluLo) && (op <= OpAluHi);
  assign is_nop  = (op == OpNop);
  assign is_halt = (op == OpHalt);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
  assign is_muldiv = (op == OpMul) || (op == OpDiv);
`else
  assign is_muldiv = 1'b0;
`endif

  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // Next state
  always_comb begin
    state_d   = state_q;
    t1_wait_d = 1'b0;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1: begin
        if (MemReady) begin
          state_d = StT2;
        end else begin
          t1_wait_d = 1'b1;
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_alu || is_muldiv) begin
          state_d = StT4;
        end else begin
          state_d = StT0;
        end
      end
      StT4:   state_d = StT5;
      StT5:   state_d = is_muldiv ? StT6 : StT0;
      StT6:   state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q   <= StReset;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Moore outputs; IR only influences T3..T6
  always_comb begin
    PCout     = 1'b0;
    ZHighout  = 1'b0;
    Zlowout   = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    ZLowIn    = 1'b0;
    ZHighIn   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    ALUop     = 5'd0;
    Rin       = '0;
    Rout      = '0;
    Run       = 1'b0;
    IllegalOp = 1'b0;
    unique case (state_q)
      StT0: begin
        Run    = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      StT1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = !t1_wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        Run = 1'b1;
        if (is_alu) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Rout = onehot(ra);
          Yin  = 1'b1;
        end else if (!is_nop && !is_halt) begin
          IllegalOp = 1'b1;
        end
      end
      StT4: begin
        Run = 1'b1;
        if (is_muldiv) begin
          Rout    = onehot(rb);
          ALUop   = op;
          ZLowIn  = 1'b1;
          ZHighIn = 1'b1;
        end else begin
          Rout   = onehot(rc);
          ALUop  = op;
          ZLowIn = 1'b1;
        end
      end
      StT5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin = onehot(ra);
        end
      end
      StT6: begin
        Run = 1'b1;
        if (is_muldiv) begin
          ZHighout = 1'b1;
          HIin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
